noise_gate_expander: RTL and testbench
======================================

Name: noise_gate_expander

Overview:
- Downward expander / noise gate: the counterpart of the soft-clip distortion stage. Distortion squashes loud samples; this block attenuates quiet ones.
- Sits in the stereo 32-bit effects chain and processes one L/R frame per sample_valid strobe.
- A peak envelope follower drives a hysteretic attack/hold/release state machine, which ramps a shared Q1.15 gain applied to both channels.

Parameters:
OPEN_THRESH, 2_000_000, envelope level (inclusive, >=) that opens the gate.
CLOSE_THRESH, 1_000_000, envelope level (exclusive, <) that starts closing; must be < OPEN_THRESH.
HOLD_SAMPLES, 480, samples the gate stays open after the envelope falls below CLOSE_THRESH.
ATTACK_STEP, 1024, gain increment per sample in ATTACK.
RELEASE_STEP, 64, gain decrement per sample in RELEASE.
RELEASE_SHIFT, 6, envelope decay: env -= env >>> RELEASE_SHIFT per sample.
FLOOR_GAIN, 0, closed-gate gain (Q1.15).

Ports:
CLOCK_50  in  1  system clock
resetn  in  1  asynchronous active-low reset
enable  in  1  0 = bypass
sample_valid  in  1  one-cycle strobe, in_L/in_R valid
in_L  in  32  signed left sample
in_R  in  32  signed right sample
out_L  out  32  signed gated left sample
out_R  out  32  signed gated right sample
out_valid  out  1  strobe, out_L/out_R valid
gate_open  out  1  high in OPEN or HOLD

Behaviour:
- One clock: CLOCK_50. Reset is asynchronous, active-low (resetn).
- Reset values: out_L = out_R = 0; out_valid = 0; gate_open = 0; state CLOSED; gain = FLOOR_GAIN; env = 0; hold counter = 0.
- Reset mid-operation takes effect immediately (async), with no partial output.
- Latency: sample_valid at edge N gives out_valid at edge N+2. Full throughput: back-to-back sample_valid is legal every cycle. Without sample_valid, nothing updates and outputs hold their values.
- Stage 1, on sample_valid:
  - abs of each channel; abs(-2^31) saturates to 2^31-1; peak = max(absL, absR).
  - env_next = peak if peak > env, else env - (env >>> RELEASE_SHIFT).
  - FSM updates on env_next; gain is updated; inputs are registered.
- Stage 2: out = (in * gain) >>> 15 as a 48-bit signed product with arithmetic shift (floor), truncated to 32 bits. Gain <= 32768 guarantees no overflow.
- Gain is unsigned 16-bit, 32768 = unity. The gain applied to frame N is the gain after frame N's FSM update.
- FSM, evaluated per sample_valid:
  - CLOSED: gain = FLOOR_GAIN. env_next >= OPEN_THRESH -> ATTACK.
  - ATTACK: gain = min(gain + ATTACK_STEP, 32768). Reaching 32768 -> OPEN. env_next < CLOSE_THRESH -> RELEASE (this takes priority).
  - OPEN: gain = 32768. env_next < CLOSE_THRESH -> HOLD, counter = HOLD_SAMPLES - 1.
  - HOLD: gain = 32768. env_next >= OPEN_THRESH -> OPEN. Else counter == 0 -> RELEASE. Else counter decrements.
  - RELEASE: gain = max(gain - RELEASE_STEP, FLOOR_GAIN). env_next >= OPEN_THRESH -> ATTACK (ramps up from the current gain). Reaching FLOOR_GAIN -> CLOSED.
  - Envelope between the thresholds: no transition (hysteresis).
- gate_open is registered with the state; high in OPEN and HOLD.
- enable = 0:
  - out = in with the same 2-cycle latency and out_valid.
  - Envelope keeps tracking; FSM is forced to OPEN, gain 32768.
  - Re-enable resumes from OPEN.
- Toggling enable mid-pipeline affects only frames whose stage 1 sees the new value.

Decomposition:
- Shared package audio_fx_pkg:
  - sample_t (logic signed [31:0]), gain_t (logic [15:0]), GAIN_UNITY = 16'd32768.
  - gate_state_e enum {CLOSED, ATTACK, OPEN, HOLD, RELEASE}.
- One sub-module: envelope_follower (abs/saturate, stereo peak, decay register; parameter RELEASE_SHIFT).
- FSM, gain ramp and multiply stay in the top module.

Test Plan:
- Reset, then 100 frames of L = R = 500_000 -> every out_L/out_R = 0; gate_open = 0; out_valid exactly 2 cycles after each sample_valid.
- Step to L = R = 8_000_000:
  - Frame 1 -> out = 250_000 (gain 1024).
  - Frame 32 -> out = 8_000_000; gate_open rises with frame 32's output.
- After opening, feed alternating ±900_000:
  - Envelope decays below 1_000_000; 480 HOLD frames at unity.
  - Then gain falls 64 per frame; CLOSED after 512 frames; out = 0 thereafter.
- During HOLD, inject one frame at 3_000_000 -> state OPEN, gain stays 32768, counter reloads on the next close.
- Opened gate with in_L = -2^31, in_R = 2^31-1 -> out_L = -2^31, out_R = 2^31-1 (no wrap). Back-to-back sample_valid every cycle -> one out_valid per input, in order.
- Assert resetn low asynchronously mid-RELEASE -> outputs 0 before the next clock edge, state CLOSED. Then enable = 0 with input 123_456 -> out = 123_456 two cycles later, regardless of gate state.

Source files
------------

// File: rtl/audio_fx_pkg.sv
// Shared types for the stereo effects chain: sample/gain types, gate states and a
// saturating absolute-value helper.
package audio_fx_pkg;

    typedef logic signed [31:0] sample_t;
    typedef logic [15:0]        gain_t;

    localparam gain_t GAIN_UNITY = 16'd32768;

    typedef enum logic [2:0] {
        CLOSED,
        ATTACK,
        OPEN,
        HOLD,
        RELEASE
    } gate_state_e;

    // The most negative sample has no positive twin; clamp it to full scale.
    function automatic logic [31:0] sat_abs(input sample_t s);
        if (s == sample_t'(32'h8000_0000)) begin
            return 32'h7fff_ffff;
        end
        return s[31] ? $unsigned(-s) : $unsigned(s);
    endfunction

endpackage

// File: rtl/noise_gate_expander_if.sv
// Sample-stream bundle for the noise gate: stereo input frame strobe and gated output frame.
interface noise_gate_expander_if;
    import audio_fx_pkg::*;

    logic    enable;
    logic    sample_valid;
    sample_t in_L;
    sample_t in_R;
    sample_t out_L;
    sample_t out_R;
    logic    out_valid;
    logic    gate_open;

    modport master (
        output enable, sample_valid, in_L, in_R,
        input  out_L, out_R, out_valid, gate_open
    );

    modport slave (
        input  enable, sample_valid, in_L, in_R,
        output out_L, out_R, out_valid, gate_open
    );

endinterface

// File: rtl/envelope_follower.sv
// Stereo peak envelope: instant attack to the louder channel's magnitude, exponential decay.
module envelope_follower
    import audio_fx_pkg::*;
#(
    parameter int unsigned RELEASE_SHIFT = 6
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  sample_t     in_l_i,
    input  sample_t     in_r_i,
    output logic [31:0] env_next_o
);

    logic [31:0] env_q, env_d;
    logic [31:0] abs_l, abs_r, peak;

    always_comb begin
        abs_l      = sat_abs(in_l_i);
        abs_r      = sat_abs(in_r_i);
        peak       = (abs_l > abs_r) ? abs_l : abs_r;
        env_next_o = (peak > env_q) ? peak : env_q - (env_q >> RELEASE_SHIFT);
        env_d      = valid_i ? env_next_o : env_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            env_q <= '0;
        end else begin
            env_q <= env_d;
        end
    end

endmodule

// File: rtl/noise_gate_expander.sv
// Downward expander / noise gate: hysteretic attack/hold/release gain control driven by a
// peak envelope, applied as a shared Q1.15 gain to both channels over a 2-stage pipeline.
module noise_gate_expander
    import audio_fx_pkg::*;
#(
    parameter int unsigned OPEN_THRESH   = 2_000_000,
    parameter int unsigned CLOSE_THRESH  = 1_000_000,
    parameter int unsigned HOLD_SAMPLES  = 480,
    parameter int unsigned ATTACK_STEP   = 1024,
    parameter int unsigned RELEASE_STEP  = 64,
    parameter int unsigned RELEASE_SHIFT = 6,
    parameter int unsigned FLOOR_GAIN    = 0
) (
    input logic                   CLOCK_50,
    input logic                   resetn,
    noise_gate_expander_if.slave  bus
);

    localparam gain_t FloorGain = gain_t'(FLOOR_GAIN);

    logic [31:0]        env_next;
    logic               open_hit, close_hit;
    gate_state_e        state_q, state_d;
    gain_t              gain_q, gain_d, gain_up, gain_dn;
    logic [16:0]        gain_up_w;
    logic [15:0]        hold_q, hold_d;
    logic               gate_q, gate_d;
    sample_t            in_l_q, in_l_d, in_r_q, in_r_d;
    logic               valid1_q;
    sample_t            out_l_q, out_l_d, out_r_q, out_r_d;
    logic               out_valid_q;
    logic signed [47:0] prod_l, prod_r;

    envelope_follower #(
        .RELEASE_SHIFT (RELEASE_SHIFT)
    ) u_env (
        .clk_i      (CLOCK_50),
        .rst_ni     (resetn),
        .valid_i    (bus.sample_valid),
        .in_l_i     (bus.in_L),
        .in_r_i     (bus.in_R),
        .env_next_o (env_next)
    );

    // Stage 1: gate FSM and gain ramp; the gain follows the state being entered.
    always_comb begin
        open_hit  = env_next >= 32'(OPEN_THRESH);
        close_hit = env_next < 32'(CLOSE_THRESH);
        gain_up_w = {1'b0, gain_q} + 17'(ATTACK_STEP);
        gain_up   = (gain_up_w >= 17'(GAIN_UNITY)) ? GAIN_UNITY : gain_up_w[15:0];
        gain_dn   = ({1'b0, gain_q} < 17'(FLOOR_GAIN) + 17'(RELEASE_STEP)) ?
                    FloorGain : gain_q - 16'(RELEASE_STEP);

        state_d = state_q;
        gain_d  = gain_q;
        hold_d  = hold_q;
        if (bus.sample_valid) begin
            if (!bus.enable) begin
                state_d = OPEN;
                gain_d  = GAIN_UNITY;
            end else begin
                unique case (state_q)
                    CLOSED:  if (open_hit) state_d = ATTACK;
                    ATTACK:  if (close_hit) state_d = RELEASE;
                    OPEN: begin
                        if (close_hit) begin
                            state_d = HOLD;
                            hold_d  = 16'(HOLD_SAMPLES - 1);
                        end
                    end
                    HOLD: begin
                        if (open_hit) begin
                            state_d = OPEN;
                        end else if (hold_q == '0) begin
                            state_d = RELEASE;
                        end else begin
                            hold_d = hold_q - 16'd1;
                        end
                    end
                    RELEASE: if (open_hit) state_d = ATTACK;
                    default: state_d = CLOSED;
                endcase

                case (state_d)
                    ATTACK:     gain_d = gain_up;
                    OPEN, HOLD: gain_d = GAIN_UNITY;
                    RELEASE:    gain_d = gain_dn;
                    default:    gain_d = FloorGain;
                endcase

                if (state_d == ATTACK && gain_d == GAIN_UNITY) state_d = OPEN;
                if (state_d == RELEASE && gain_d == FloorGain) state_d = CLOSED;
            end
        end
        gate_d = (state_d == OPEN) || (state_d == HOLD);
        in_l_d = bus.sample_valid ? bus.in_L : in_l_q;
        in_r_d = bus.sample_valid ? bus.in_R : in_r_q;
    end

    // Stage 2: Q1.15 multiply with flooring shift; unity gain passes samples untouched.
    always_comb begin
        prod_l  = $signed({{16{in_l_q[31]}}, in_l_q}) * $signed({32'd0, gain_q});
        prod_r  = $signed({{16{in_r_q[31]}}, in_r_q}) * $signed({32'd0, gain_q});
        out_l_d = valid1_q ? sample_t'(prod_l >>> 15) : out_l_q;
        out_r_d = valid1_q ? sample_t'(prod_r >>> 15) : out_r_q;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q     <= CLOSED;
            gain_q      <= FloorGain;
            hold_q      <= '0;
            gate_q      <= 1'b0;
            in_l_q      <= '0;
            in_r_q      <= '0;
            valid1_q    <= 1'b0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gain_q      <= gain_d;
            hold_q      <= hold_d;
            gate_q      <= gate_d;
            in_l_q      <= in_l_d;
            in_r_q      <= in_r_d;
            valid1_q    <= bus.sample_valid;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            out_valid_q <= valid1_q;
        end
    end

    assign bus.out_L     = out_l_q;
    assign bus.out_R     = out_r_q;
    assign bus.out_valid = out_valid_q;
    assign bus.gate_open = gate_q;

endmodule

// File: tb/tb_noise_gate_expander.sv
// Bench for noise_gate_expander: per-frame behavioural model with a scoreboard queue,
// checked on every out_valid, plus hand-computed literal checks.
module tb_noise_gate_expander;

    localparam int MinS = 32'sh8000_0000;
    localparam int MaxS = 32'sh7fff_ffff;

    typedef enum int {M_CLOSED, M_ATTACK, M_OPEN, M_HOLD, M_RELEASE} mst_t;
    typedef struct {
        int l;
        int r;
        bit gate;
        bit gchk;
        int issue;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    exp_t q[$];
    exp_t ce;
    logic signed [31:0] last_l = '0;
    logic signed [31:0] last_r = '0;
    logic               last_gate = 1'b0;

    mst_t   m_st;
    longint m_env;
    int     m_gain;
    int     m_cnt;

    noise_gate_expander_if bus ();

    noise_gate_expander dut (
        .CLOCK_50 (clk),
        .resetn   (rst_n),
        .bus      (bus)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every out_valid must match the oldest pending frame, two cycles later.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", 1, 0);
            end else begin
                ce = q.pop_front();
                chk("out_L", bus.out_L, ce.l);
                chk("out_R", bus.out_R, ce.r);
                chk("latency", cyc - ce.issue, 2);
                if (ce.gchk) chk("gate_open", bus.gate_open, ce.gate);
                last_l    <= bus.out_L;
                last_r    <= bus.out_R;
                last_gate <= bus.gate_open;
            end
        end
    end

    task automatic model_reset();
        m_st = M_CLOSED; m_env = 0; m_gain = 0; m_cnt = 0;
        q.delete();
    endtask

    task automatic ramp_up();
        m_gain = (m_gain + 1024 > 32768) ? 32768 : m_gain + 1024;
        if (m_gain == 32768) m_st = M_OPEN;
    endtask

    task automatic ramp_down();
        m_gain = (m_gain - 64 < 0) ? 0 : m_gain - 64;
        if (m_gain == 0) m_st = M_CLOSED;
    endtask

    task automatic model_frame(input int l, input int r, input bit en,
                               output int ol, output int orr, output bit gate);
        longint al, ar, pk;
        al = l; if (al < 0) al = -al; if (al > 64'd2147483647) al = 64'd2147483647;
        ar = r; if (ar < 0) ar = -ar; if (ar > 64'd2147483647) ar = 64'd2147483647;
        pk = (al > ar) ? al : ar;
        if (pk > m_env) m_env = pk;
        else m_env = m_env - (m_env >>> 6);
        if (!en) begin
            m_st = M_OPEN; m_gain = 32768;
        end else begin
            case (m_st)
                M_CLOSED:  if (m_env >= 2000000) begin m_st = M_ATTACK; ramp_up(); end
                           else m_gain = 0;
                M_ATTACK:  if (m_env < 1000000) begin m_st = M_RELEASE; ramp_down(); end
                           else ramp_up();
                M_OPEN: begin
                    m_gain = 32768;
                    if (m_env < 1000000) begin m_st = M_HOLD; m_cnt = 479; end
                end
                M_HOLD: begin
                    if (m_env >= 2000000) m_st = M_OPEN;
                    else if (m_cnt == 0) begin m_st = M_RELEASE; ramp_down(); end
                    else m_cnt--;
                end
                default:   if (m_env >= 2000000) begin m_st = M_ATTACK; ramp_up(); end
                           else ramp_down();
            endcase
        end
        ol   = int'((longint'(l) * longint'(m_gain)) >>> 15);
        orr  = int'((longint'(r) * longint'(m_gain)) >>> 15);
        gate = (m_st == M_OPEN) || (m_st == M_HOLD);
    endtask

    task automatic send(input int l, input int r, input bit en, input bit gchk);
        exp_t e;
        int   ol, orr;
        bit   g;
        model_frame(l, r, en, ol, orr, g);
        e = '{l: ol, r: orr, gate: g, gchk: gchk, issue: cyc};
        q.push_back(e);
        bus.enable = en; bus.in_L = l; bus.in_R = r; bus.sample_valid = 1'b1;
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic frame(input int l, input int r, input bit en);
        send(l, r, en, 1'b1);
        idle(2);
    endtask

    task automatic alt_until_gate_low(input string name);
        int  k = 0;
        bit  pos = 1'b1;
        while (last_gate && k < 3000) begin
            frame(pos ? 900000 : -900000, pos ? 900000 : -900000, 1'b1);
            pos = ~pos; k++;
        end
        chk(name, last_gate, 0);
    endtask

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: simulation exceeded time budget");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

    initial begin
        int  k, rel;
        bit  pos;
        bus.enable = 1'b1; bus.sample_valid = 1'b0; bus.in_L = 0; bus.in_R = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_L", bus.out_L, 0);
        chk("reset_out_R", bus.out_R, 0);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_gate", bus.gate_open, 0);
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 100; i++) frame(500000, 500000, 1'b1);
        chk("quiet_out", last_l, 0);
        chk("quiet_gate", last_gate, 0);

        frame(8000000, 8000000, 1'b1);
        chk("attack_f1_out", last_l, 250000);
        for (int i = 2; i <= 31; i++) frame(8000000, 8000000, 1'b1);
        chk("attack_f31_gate", last_gate, 0);
        frame(8000000, 8000000, 1'b1);
        chk("attack_f32_out", last_l, 8000000);
        chk("attack_f32_gate", last_gate, 1);

        // Decay into HOLD, then re-open from HOLD with one loud frame.
        k = 0; pos = 1'b1;
        while (m_st != M_HOLD && k < 1000) begin
            frame(pos ? 900000 : -900000, pos ? 900000 : -900000, 1'b1);
            pos = ~pos; k++;
        end
        for (int i = 0; i < 10; i++) begin
            frame(pos ? 900000 : -900000, pos ? 900000 : -900000, 1'b1);
            pos = ~pos;
        end
        frame(3000000, 3000000, 1'b1);
        chk("hold_reopen_out", last_l, 3000000);
        chk("hold_reopen_gate", last_gate, 1);

        // Back-to-back frames at full scale through an open gate.
        send(1000000, -1000000, 1'b1, 1'b0);
        send(-7, 7, 1'b1, 1'b0);
        send(MinS, MaxS, 1'b1, 1'b0);
        idle(3);
        chk("extreme_out_L", last_l, -64'sd2147483648);
        chk("extreme_out_R", last_r, 64'sd2147483647);

        alt_until_gate_low("hold_expired");
        rel = 1; pos = 1'b1;
        while (last_l != 0 && rel < 600) begin
            frame(pos ? 900000 : -900000, pos ? 900000 : -900000, 1'b1);
            pos = ~pos; rel++;
        end
        chk("release_frames", rel, 512);
        for (int i = 0; i < 5; i++) frame(900000, -900000, 1'b1);
        chk("closed_out", last_l, 0);
        chk("closed_gate", last_gate, 0);

        // Reopen, decay into RELEASE, then reset asynchronously between clock edges.
        for (int i = 0; i < 32; i++) frame(8000000, 8000000, 1'b1);
        chk("reopen_gate", last_gate, 1);
        alt_until_gate_low("second_hold_expired");
        for (int i = 0; i < 20; i++) frame(900000, 900000, 1'b1);
        chk("release_queue_empty", q.size(), 0);
        @(negedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_L", bus.out_L, 0);
        chk("async_rst_out_R", bus.out_R, 0);
        chk("async_rst_valid", bus.out_valid, 0);
        chk("async_rst_gate", bus.gate_open, 0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        frame(500000, 500000, 1'b1);
        chk("post_rst_closed_out", last_l, 0);
        frame(3000000, 3000000, 1'b1);
        chk("post_rst_attack_out", last_l, 93750);
        frame(123456, 123456, 1'b0);
        chk("bypass_out", last_l, 123456);
        chk("bypass_gate", last_gate, 1);
        frame(500000, -500000, 1'b1);
        chk("reenable_out_L", last_l, 500000);
        chk("reenable_out_R", last_r, -500000);
        chk("reenable_gate", last_gate, 1);

        idle(4);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
